// File: rtl/bus_target_if.sv
// Bus and consumer-side signals of the dValid/dAck byte-transfer target.
// slave: the target end; master: the bus master plus FIFO consumer.
interface bus_target_if #(
   parameter int unsigned DEPTH = 4
);
   logic                     dValid;
   logic [7:0]               data;
   logic                     dAck;
   logic                     rd_en;
   logic [7:0]               rd_data;
   logic                     empty;
   logic                     full;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;
   logic                     proto_err;

   modport slave (
      input  dValid, data, rd_en,
      output dAck, rd_data, empty, full, count, overflow, proto_err
   );

   modport master (
      output dValid, data, rd_en,
      input  dAck, rd_data, empty, full, count, overflow, proto_err
   );
endinterface

// File: rtl/bus_target.sv
// Target end of the dValid/dAck bus: detects transfer starts, acknowledges
// after ACK_DLY cycles (3 when the FIFO is full at the start), stores the
// byte in a first-word-fall-through FIFO and flags master protocol errors.
module bus_target #(
   parameter int unsigned ACK_DLY = 2,
   parameter int unsigned DEPTH   = 4
) (
   input  logic         clk,
   input  logic         reset,
   bus_target_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   if (ACK_DLY < 1 || ACK_DLY > 3) begin : g_bad_ack_dly
      $error("bus_target: ACK_DLY must be in 1..3");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("bus_target: DEPTH must be a power of two, at least 2");
   end

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_prev_dv;
   logic [1:0]      r_k;
   logic [1:0]      w_kload;
   logic            w_start;
   logic [7:0]      r_t0_data;
   logic [7:0]      r_latch;
   logic            r_data_err;
   logic            r_first_done;
   logic            r_dAck;
   logic            r_proto;
   logic            w_err;
   logic            w_mismatch;
   logic            w_push;
   logic            w_pop;
   logic            w_ovf_set;

   logic [7:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr;
   logic [AW-1:0]   r_rd;
   logic [CW-1:0]   r_count;
   logic            r_overflow;
   logic            w_full;
   logic            w_empty;

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_start  = bus.dValid & ~r_prev_dv;
   assign w_kload  = w_full ? 2'd3 : ACK_DLY[1:0];

   // State register plus the control registers that follow the FSM.
   // The acknowledge is registered on entry to ACK, so dAck is a clean
   // flop output that is high exactly while the FSM sits in ACK.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_prev_dv    <= 1'b1;
         r_k          <= '0;
         r_t0_data    <= '0;
         r_latch      <= '0;
         r_data_err   <= 1'b0;
         r_first_done <= 1'b0;
         r_dAck       <= 1'b0;
         r_proto      <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_prev_dv    <= bus.dValid;
         r_first_done <= (r_state == S_ACK);
         r_dAck       <= (w_next == S_ACK);
         r_proto      <= w_err;
         if (r_state == S_IDLE && w_start) begin
            r_k        <= w_kload - 2'd1;
            r_t0_data  <= bus.data;
            r_data_err <= 1'b0;
         end else if (r_state == S_WAIT) begin
            r_k <= r_k - 2'd1;
            if (w_mismatch) r_data_err <= 1'b1;
         end
         if (w_next == S_ACK) r_latch <= bus.data;
      end
   end

   // Next-state logic; a one-cycle delay goes straight from IDLE to ACK.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_start) w_next = (w_kload == 2'd1) ? S_ACK : S_WAIT;
         S_WAIT: begin
            if (!bus.dValid)      w_next = S_IDLE;
            else if (r_k == 2'd1) w_next = S_ACK;
         end
         S_ACK:  w_next = S_DONE;
         S_DONE: if (!bus.dValid) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM outputs: FIFO push/pop requests and protocol-error detection.
   always_comb begin
      w_mismatch = (r_state == S_WAIT) && (bus.data != r_t0_data) && !r_data_err;
      w_err      = ((r_state == S_WAIT) && !bus.dValid) || w_mismatch ||
                   ((r_state == S_DONE) && r_first_done && bus.dValid);
      w_pop      = bus.rd_en && !w_empty;
      w_push     = (r_state == S_ACK) && (!w_full || bus.rd_en);
      w_ovf_set  = (r_state == S_ACK) && w_full && !bus.rd_en;
   end

   // FIFO storage, pointers, occupancy and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr       <= '0;
         r_rd       <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= r_latch;
            r_wr        <= r_wr + AW'(1);
         end
         if (w_pop) r_rd <= r_rd + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
         if (w_ovf_set) r_overflow <= 1'b1;
      end
   end

   assign bus.dAck      = r_dAck;
   assign bus.proto_err = r_proto;
   assign bus.rd_data   = r_mem[r_rd];
   assign bus.empty     = w_empty;
   assign bus.full      = w_full;
   assign bus.count     = r_count;
   assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_bus_target.sv
// Scoreboard bench for bus_target: three instances (ACK_DLY 2, 1, 3; DEPTH 4).
// Stimulus pushes expected events; one monitor pops and compares them.
module tb_bus_target;
   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  dv;
   logic [2:0]  rd;
   logic [7:0]  dat [3];
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bus_target_if #(.DEPTH(4)) if_a ();
   bus_target_if #(.DEPTH(4)) if_b ();
   bus_target_if #(.DEPTH(4)) if_c ();

   bus_target #(.ACK_DLY(2), .DEPTH(4)) u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
   bus_target #(.ACK_DLY(1), .DEPTH(4)) u_b (.clk(clk), .reset(reset), .bus(if_b.slave));
   bus_target #(.ACK_DLY(3), .DEPTH(4)) u_c (.clk(clk), .reset(reset), .bus(if_c.slave));

   assign if_a.dValid = dv[0]; assign if_a.data = dat[0]; assign if_a.rd_en = rd[0];
   assign if_b.dValid = dv[1]; assign if_b.data = dat[1]; assign if_b.rd_en = rd[1];
   assign if_c.dValid = dv[2]; assign if_c.data = dat[2]; assign if_c.rd_en = rd[2];

   logic [2:0] o_ack, o_perr, o_empty, o_full, o_ovf;
   logic [7:0] o_rd [3];
   int         o_cnt [3];

   assign o_ack   = {if_c.dAck, if_b.dAck, if_a.dAck};
   assign o_perr  = {if_c.proto_err, if_b.proto_err, if_a.proto_err};
   assign o_empty = {if_c.empty, if_b.empty, if_a.empty};
   assign o_full  = {if_c.full, if_b.full, if_a.full};
   assign o_ovf   = {if_c.overflow, if_b.overflow, if_a.overflow};
   assign o_rd[0] = if_a.rd_data; assign o_rd[1] = if_b.rd_data; assign o_rd[2] = if_c.rd_data;
   assign o_cnt[0] = int'(if_a.count);
   assign o_cnt[1] = int'(if_b.count);
   assign o_cnt[2] = int'(if_c.count);

   // kinds: 0 dAck cycle, 1 proto_err cycle, 2 popped byte,
   // 3 count, 4 empty, 5 full, 6 overflow, 7 head byte, 8 dAck level, 9 proto_err level
   typedef struct {
      int kind;
      int dut;
      int cyc;
      int val;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   done    = 1'b0;

   function automatic string kname(input int k);
      case (k)
         0: return "dAck_cycle";
         1: return "proto_err_cycle";
         2: return "pop_data";
         3: return "count";
         4: return "empty";
         5: return "full";
         6: return "overflow";
         7: return "head_data";
         8: return "dAck_level";
         default: return "proto_err_level";
      endcase
   endfunction

   function automatic int status_val(input int k, input int d);
      case (k)
         3: return o_cnt[d];
         4: return int'(o_empty[d]);
         5: return int'(o_full[d]);
         6: return int'(o_ovf[d]);
         7: return int'(o_rd[d]);
         8: return int'(o_ack[d]);
         default: return int'(o_perr[d]);
      endcase
   endfunction

   task automatic expect_ev(input int kind, input int d, input int c, input int v);
      exp_t e;
      e.kind = kind; e.dut = d; e.cyc = c; e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic expect_status(input int d, input int cnt, input int emp, input int ful, input int ovf);
      expect_ev(3, d, cyc, cnt);
      expect_ev(4, d, cyc, emp);
      expect_ev(5, d, cyc, ful);
      expect_ev(6, d, cyc, ovf);
   endtask

   // Event matcher: first pending expectation of this kind for this DUT.
   task automatic match_ev(input int kind, input int d, input int act);
      int idx = -1;
      foreach (exp_q[i])
         if (idx < 0 && exp_q[i].kind == kind && exp_q[i].dut == d) idx = i;
      n_tests++;
      if (idx < 0) begin
         n_fail++;
         $display("FAIL %s dut%0d: unexpected event, actual %0d (cycle %0d), required none",
                  kname(kind), d, act, cyc);
      end else begin
         if (exp_q[idx].val != act) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual %0d, required %0d (cycle %0d)",
                     kname(kind), d, act, exp_q[idx].val, cyc);
         end
         exp_q.delete(idx);
      end
   endtask

   // Monitor: compares whatever the DUTs present on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (o_ack[d])              match_ev(0, d, cyc);
            if (o_perr[d])             match_ev(1, d, cyc);
            if (rd[d] && !o_empty[d])  match_ev(2, d, int'(o_rd[d]));
         end
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].kind >= 3 && exp_q[i].cyc == cyc) begin
               n_tests++;
               if (status_val(exp_q[i].kind, exp_q[i].dut) != exp_q[i].val) begin
                  n_fail++;
                  $display("FAIL %s dut%0d: actual %0d, required %0d (cycle %0d)",
                           kname(exp_q[i].kind), exp_q[i].dut,
                           status_val(exp_q[i].kind, exp_q[i].dut), exp_q[i].val, cyc);
               end
               exp_q.delete(i);
            end
         end
         if (done) begin
            foreach (exp_q[i]) begin
               n_tests++;
               n_fail++;
               $display("FAIL %s dut%0d: never observed, actual none, required %0d",
                        kname(exp_q[i].kind), exp_q[i].dut, exp_q[i].val);
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
         end
         if (cyc > 3000) begin
            $display("FAIL watchdog: actual cycle %0d, required end before 3000", cyc);
            $fatal(1, "watchdog");
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One master transfer: dValid high for k+1+extra cycles; data switches
   // to b2 in T0+1; optional pop request in the dAck cycle.
   task automatic xfer(input int d, input logic [7:0] b, input logic [7:0] b2, input int k,
                       input bit stored, input bit rd_at_ack, input int extra);
      int t0;
      step();
      t0 = cyc;
      dv[d]  = 1'b1;
      dat[d] = b;
      expect_ev(0, d, 0, t0 + k);
      if (stored)             expect_ev(2, d, 0, (k >= 2) ? int'(b2) : int'(b));
      if (k >= 2 && b2 != b)  expect_ev(1, d, 0, t0 + 2);
      if (extra > 0)          expect_ev(1, d, 0, t0 + k + 2);
      for (int i = 1; i <= k; i++) begin
         step();
         if (i == 1) dat[d] = b2;
      end
      if (rd_at_ack) rd[d] = 1'b1;
      repeat (extra) begin
         step();
         rd[d] = 1'b0;
      end
      step();
      dv[d] = 1'b0;
      rd[d] = 1'b0;
   endtask

   task automatic rd_n(input int d, input int n);
      repeat (n) begin
         step();
         rd[d] = 1'b1;
      end
      step();
      rd[d] = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      dv    = 3'b001;   // DUT a sees dValid already high out of reset
      rd    = '0;
      for (int d = 0; d < 3; d++) dat[d] = 8'h00;
      step();                                    // cycle 1, in reset
      for (int d = 0; d < 3; d++) begin
         expect_status(d, 0, 1, 0, 0);
         expect_ev(8, d, cyc, 0);
         expect_ev(9, d, cyc, 0);
      end
      step();
      reset = 1'b0;
      while (cyc < 7) step();
      dv[0] = 1'b0;
      while (cyc < 9) step();

      // Nominal: T0=10, dAck in 12, byte visible in 13.
      xfer(0, 8'hA5, 8'hA5, 2, 1'b1, 1'b0, 0);
      expect_status(0, 1, 0, 0, 0);
      expect_ev(7, 0, cyc, 8'hA5);
      rd_n(0, 1);
      expect_status(0, 0, 1, 0, 0);

      // Data change in WAIT; the byte taken at the dAck edge is stored.
      xfer(0, 8'h10, 8'h11, 2, 1'b1, 1'b0, 0);
      rd_n(0, 1);
      // dValid held past the dAck: one proto_err only.
      xfer(0, 8'h30, 8'h30, 2, 1'b1, 1'b0, 2);
      rd_n(0, 1);

      // Read while empty.
      rd_n(0, 3);
      expect_status(0, 0, 1, 0, 0);

      // Fill, overflow, then replace-at-full with a pop in the dAck cycle.
      xfer(0, 8'h21, 8'h21, 2, 1'b1, 1'b0, 0);
      xfer(0, 8'h22, 8'h22, 2, 1'b1, 1'b0, 0);
      xfer(0, 8'h23, 8'h23, 2, 1'b1, 1'b0, 0);
      xfer(0, 8'h24, 8'h24, 2, 1'b1, 1'b0, 0);
      expect_status(0, 4, 0, 1, 0);
      xfer(0, 8'h55, 8'h55, 3, 1'b0, 1'b0, 0);
      expect_status(0, 4, 0, 1, 1);
      xfer(0, 8'h66, 8'h66, 3, 1'b1, 1'b1, 0);
      expect_status(0, 4, 0, 1, 1);
      expect_ev(7, 0, cyc, 8'h22);
      rd_n(0, 4);
      expect_status(0, 0, 1, 0, 1);

      // ACK_DLY=1 sweep.
      for (int i = 1; i <= 4; i++) xfer(1, 8'(i), 8'(i), 1, 1'b1, 1'b0, 0);
      expect_status(1, 4, 0, 1, 0);
      rd_n(1, 4);
      expect_status(1, 0, 1, 0, 0);

      // ACK_DLY=3: abort at T0+1, then sweep.
      begin
         int t0;
         step();
         t0 = cyc;
         dv[2]  = 1'b1;
         dat[2] = 8'h77;
         expect_ev(1, 2, 0, t0 + 2);
         step();
         dv[2] = 1'b0;
         step();
         expect_status(2, 0, 1, 0, 0);
      end
      for (int i = 1; i <= 4; i++) xfer(2, 8'(i), 8'(i), 3, 1'b1, 1'b0, 0);
      expect_status(2, 4, 0, 1, 0);
      rd_n(2, 4);

      // Reset in WAIT with dValid held high: transfer dropped, no restart.
      step();
      dv[2]  = 1'b1;
      dat[2] = 8'h99;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      expect_status(0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         expect_status(2, 0, 1, 0, 0);
         expect_ev(8, 2, cyc, 0);
         step();
      end
      dv[2] = 1'b0;
      xfer(2, 8'h5A, 8'h5A, 3, 1'b1, 1'b0, 0);
      expect_status(2, 1, 0, 0, 0);
      rd_n(2, 1);

      repeat (4) step();
      done = 1'b1;
   end
endmodule

// File: doc/bus_target.md
# bus_target

Target (receiving) end of the dValid/dAck byte-transfer bus. It detects the start of each master transfer and issues a single-cycle `dAck` inside the legal 2–4-clock `dValid` window. It captures the stable `data` byte into a first-word-fall-through FIFO and flags protocol violations by the master. It sits between the bus and the downstream consumer that drains the FIFO.

## Interface
- `ACK_DLY`, 2, cycles from transfer start to `dAck`; legal range 1..3, other values are an elaboration error.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dValid`  in  1  master data-valid.
- `data`  in  8  master data byte.
- `dAck`  out  1  target acknowledge, one-cycle pulse.
- `rd_en`  in  1  consumer pop request.
- `rd_data`  out  8  FIFO head; valid while `!empty`.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: a byte was acknowledged but dropped.
- `proto_err`  out  1  one-cycle pulse: the master broke the protocol.

## Operation
- Start detect: a cycle where `dValid`=1 and the registered previous `dValid`=0. That cycle is T0. The previous-`dValid` register resets to 1, so a `dValid` already high out of reset is ignored until it has been seen low.
- FSM states: IDLE, WAIT, ACK, DONE.
  - IDLE: on start, load delay counter k = (full ? 3 : ACK_DLY) and go to WAIT.
  - WAIT: decrement k each cycle. When k reaches 1, register `dAck`=1, latch `data`, and go to ACK, so `dAck` is high in cycle T0+k.
  - ACK: `dAck`=1 for exactly this cycle. Push the latched byte if space exists, otherwise set `overflow`. Go to DONE.
  - DONE: expects `dValid`=0 in cycle T0+k+1.
    - If it is low: go to IDLE.
    - If it is high: pulse `proto_err` once and stay in DONE until `dValid`=0, then go to IDLE.
- Abort: if `dValid` drops while in WAIT, pulse `proto_err`, go to IDLE, issue no `dAck`, push nothing.
- Data check: if `data` differs from its T0 value while in WAIT, pulse `proto_err` (at most once per transfer). The latched value is still taken at the `dAck` edge.
- FIFO push:
  - Allowed when `!full`, or when `full` and `rd_en` is asserted in the same cycle; in that case count is unchanged.
  - When neither holds, the byte is dropped and `overflow` is set and held until reset.
- FIFO pop: `rd_en` with `!empty` advances the head. `rd_en` while empty is ignored and raises no error.
- Pointers wrap modulo DEPTH.
- `count` is 0..DEPTH. `full` is (count==DEPTH) and `empty` is (count==0); both are registered-consistent with `count`.

## Timing
- Reset values: `dAck`=0, `proto_err`=0, `overflow`=0, `count`=0, `empty`=1, `full`=0, `rd_data`=don't-care (0 in simulation), FSM in IDLE.
- Reset mid-transfer: aborts the transfer with no `dAck` and clears the FIFO. The master's `dValid` is ignored until it is seen low.
- `dAck` rises in T0+ACK_DLY (1..3), or in T0+3 if the FIFO was full at T0. This gives the master a `dValid` length of ACK_DLY+1 (2..4) clocks.
- `dAck` is never asserted in T0, and never after T0+3.
- Push lands at the end of the `dAck` cycle. `count`, `empty` and `rd_data` update in T0+k+1.
- `rd_data` is combinational from FIFO memory at the head pointer (FWFT). Pop takes effect at the clock edge.
- A new start may occur in T0+k+2 at the earliest: `dValid` must be low for one cycle first.
- `proto_err` pulses are registered, one cycle after the offending sample.

## Test plan
- Nominal, ACK_DLY=2: `dValid` rises at cycle 10 with `data`=0xA5 and drops at 13 -> `dAck`=1 only in cycle 12, `count`=1 and `rd_data`=0xA5 in cycle 13, no `proto_err`.
- Delay sweep, ACK_DLY=1 and 3: `dAck` in T0+1 and T0+3 respectively. Back-to-back bytes 0x01..0x04 with one idle cycle between transfers -> FIFO pops return 0x01,0x02,0x03,0x04 in order.
- Full/overflow, DEPTH=4, no reads: 4 transfers fill the FIFO (`full`=1). The 5th transfer (0x55) gets `dAck` at T0+3, is dropped, and sets `overflow`=1. A 6th transfer with `rd_en` pulsed in its `dAck` cycle keeps `count`=4 and its byte becomes the tail.
- Protocol errors:
  - `dValid` drops at T0+1 with ACK_DLY=3 -> `proto_err` pulse, no `dAck`, `count` unchanged.
  - `dValid` held through T0+k+1 -> exactly one `proto_err` pulse.
  - `data` changes 0x10 -> 0x11 in WAIT -> one `proto_err` pulse.
- Reset cases:
  - `reset` asserted in WAIT while `dValid` stays high -> no `dAck`, `count`=0, no new transfer until `dValid` has been seen low then high.
  - `dValid` high out of reset -> ignored.
- Empty read: `rd_en`=1 with `count`=0 for 3 cycles -> `count` stays 0, `empty` stays 1, no error.
